bcd_serial_addsub: RTL and testbench

Parametrised multi-digit BCD adder/subtractor that processes one decimal digit per clock, least-significant digit first, under a start/busy/done handshake. It generalises the single-digit combinational BCD adder to DIGITS digits, adds ten's-complement subtraction and invalid-digit detection, and trades latency for a single shared digit-correction datapath. It sits between operand registers and the decimal display/accumulator logic of the calculator datapath.

---
 rtl/bcd_serial_addsub_if.sv | 18 +
 rtl/bcd_serial_addsub.sv | 108 ++++++++++
 tb/tb_bcd_serial_addsub.sv | 126 ++++++++++++
 3 files changed

// File: rtl/bcd_serial_addsub_if.sv
// Handshake and operand/result bundle for the digit-serial BCD adder/subtractor.
interface bcd_serial_addsub_if #(parameter int DIGITS = 4);
    logic                  start;
    logic                  sub;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  c_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   result;
    logic                  c_out;
    logic                  err;

    modport master (output start, sub, a, b, c_in,
                    input  busy, done, result, c_out, err);
    modport slave  (input  start, sub, a, b, c_in,
                    output busy, done, result, c_out, err);
endinterface

// File: rtl/bcd_serial_addsub.sv
// Multi-digit BCD add/subtract, one digit per clock, LSD first, sharing one
// digit-correction datapath. Subtraction uses nine's complement of b plus carry.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one digit of the operands processed per cycle
// DONE  | one-cycle done pulse, a new start is accepted here
module bcd_serial_addsub #(
    parameter int DIGITS = 4
) (
    input  logic clk,
    input  logic rst_n,
    bcd_serial_addsub_if.slave bus
);
    localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state;
    logic [4*DIGITS-1:0] a_q;
    logic [4*DIGITS-1:0] b_q;
    logic                sub_q;
    logic                carry;
    logic [KW-1:0]       k;
    logic [4*DIGITS-1:0] result_q;
    logic                c_out_q;
    logic                err_q;
    logic                busy_q;
    logic                done_q;

    logic                bad_digit;
    logic [3:0]          b_adj;
    logic [4:0]          t;
    logic [3:0]          digit;
    logic                carry_next;

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.a[4*i +: 4] > 4'd9 || bus.b[4*i +: 4] > 4'd9)
                bad_digit = 1'b1;
        end
    end

    // Operands shift right each RUN cycle so the current digit is always in [3:0].
    always_comb begin
        b_adj      = sub_q ? (4'd9 - b_q[3:0]) : b_q[3:0];
        t          = 5'(a_q[3:0]) + 5'(b_adj) + 5'(carry);
        carry_next = (t > 5'd9);
        digit      = carry_next ? (t[3:0] + 4'd6) : t[3:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            carry    <= 1'b0;
            k        <= '0;
            result_q <= '0;
            c_out_q  <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q      <= bus.a;
                        b_q      <= bus.b;
                        sub_q    <= bus.sub;
                        carry    <= bus.sub ? ~bus.c_in : bus.c_in;
                        err_q    <= bad_digit;
                        result_q <= '0;
                        k        <= '0;
                        busy_q   <= 1'b1;
                        state    <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    result_q[{k, 2'b00} +: 4] <= digit;
                    carry <= carry_next;
                    a_q   <= a_q >> 4;
                    b_q   <= b_q >> 4;
                    k     <= k + 1'b1;
                    if (k == K_LAST) begin
                        c_out_q <= sub_q ? ~carry_next : carry_next;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state   <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.c_out  = c_out_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed bench for bcd_serial_addsub (DIGITS=4) using immediate assertions.
module tb_bcd_serial_addsub;
    logic clk;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    bcd_serial_addsub_if #(.DIGITS(4)) bus ();

    bcd_serial_addsub #(.DIGITS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one operation and checks accept state, latency, results and pulse width.
    // glitch: pulse start with other operands mid-RUN; keep_done: leave the done
    // cycle unconsumed so the caller can start the next operation in it.
    task automatic run_op(input string tag, input logic s, input logic [15:0] av,
                          input logic [15:0] bv, input logic ci,
                          input logic [15:0] exp_res, input logic exp_cout,
                          input logic exp_err, input bit glitch, input bit keep_done);
        int cnt;
        @(negedge clk);
        bus.sub = s; bus.a = av; bus.b = bv; bus.c_in = ci; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk({tag, " busy@accept"}, 32'(bus.busy), 32'd1);
        chk({tag, " done@accept"}, 32'(bus.done), 32'd0);
        chk({tag, " result@accept"}, 32'(bus.result), 32'd0);
        chk({tag, " err@accept"}, 32'(bus.err), 32'(exp_err));
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (glitch && cnt == 1) begin
                bus.start = 1'b1; bus.a = 16'h9999; bus.b = 16'h9999; bus.sub = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            cnt++;
            if (bus.done) break;
        end
        chk({tag, " latency"}, 32'(cnt), 32'd4);
        chk({tag, " busy@done"}, 32'(bus.busy), 32'd0);
        chk({tag, " result"}, 32'(bus.result), 32'(exp_res));
        chk({tag, " c_out"}, 32'(bus.c_out), 32'(exp_cout));
        chk({tag, " err@done"}, 32'(bus.err), 32'(exp_err));
        if (!keep_done) begin
            @(posedge clk); #1;
            chk({tag, " done width"}, 32'(bus.done), 32'd0);
            chk({tag, " result hold"}, 32'(bus.result), 32'(exp_res));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0; bus.c_in = 1'b0;
        #12;
        chk("reset busy",   32'(bus.busy),   32'd0);
        chk("reset done",   32'(bus.done),   32'd0);
        chk("reset result", 32'(bus.result), 32'd0);
        chk("reset c_out",  32'(bus.c_out),  32'd0);
        chk("reset err",    32'(bus.err),    32'd0);
        @(negedge clk); rst_n = 1'b1;

        run_op("add1234+5678", 1'b0, 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 0, 0);
        run_op("add9999+0001", 1'b0, 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 0);
        run_op("add0+0+cin",   1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 0, 0);
        run_op("sub5000-1234", 1'b1, 16'h5000, 16'h1234, 1'b0, 16'h3766, 1'b0, 1'b0, 0, 0);
        run_op("sub5000-1234-1", 1'b1, 16'h5000, 16'h1234, 1'b1, 16'h3765, 1'b0, 1'b0, 0, 0);
        run_op("sub0123-0456", 1'b1, 16'h0123, 16'h0456, 1'b0, 16'h9667, 1'b1, 1'b0, 0, 0);

        // Raw-nibble arithmetic on 0x00A0+0x0001: digit1 10 -> 0 carry 1.
        run_op("err00A0", 1'b0, 16'h00A0, 16'h0001, 1'b0, 16'h0101, 1'b0, 1'b1, 0, 0);
        repeat (2) @(posedge clk);
        #1 chk("err held", 32'(bus.err), 32'd1);
        run_op("err clear", 1'b0, 16'h0011, 16'h0022, 1'b0, 16'h0033, 1'b0, 1'b0, 0, 0);

        run_op("glitch", 1'b0, 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1, 0);

        run_op("b2b first",  1'b0, 16'h2500, 16'h2500, 1'b0, 16'h5000, 1'b0, 1'b0, 0, 1);
        run_op("b2b second", 1'b1, 16'h0100, 16'h0001, 1'b0, 16'h0099, 1'b0, 1'b0, 0, 0);

        // Abort after digit 1 is written.
        @(negedge clk);
        bus.sub = 1'b0; bus.a = 16'h1234; bus.b = 16'h5678; bus.c_in = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort partial", 32'(bus.result), 32'h0012);
        #2 rst_n = 1'b0;
        #1;
        chk("abort busy",   32'(bus.busy),   32'd0);
        chk("abort done",   32'(bus.done),   32'd0);
        chk("abort result", 32'(bus.result), 32'd0);
        chk("abort c_out",  32'(bus.c_out),  32'd0);
        chk("abort err",    32'(bus.err),    32'd0);
        repeat (3) @(posedge clk);
        #1 chk("abort no done", 32'(bus.done), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1 chk("post-reset no done", 32'(bus.done), 32'd0);

        run_op("add0042+0058", 1'b0, 16'h0042, 16'h0058, 1'b0, 16'h0100, 1'b0, 1'b0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
